planes_cache_ctrl: RTL and testbench

- Scan sequencer for the HUB75-style LED matrix path.
- Fetches the upper-half and lower-half RGB row planes from frame memory and drives LOAD0/LOAD1/SHIFT into the 64-pixel planes cache.
- Generates the panel clock, latch, output-enable and row address.
- Runs binary-coded-modulation (BCM) bit-plane timing: rows in order, and within each row, bit-planes in order.

---
 rtl/planes_cache_ctrl_pkg.sv | 37 +++
 rtl/planes_cache_ctrl_if.sv | 21 ++
 rtl/planes_cache_ctrl_bcm_plane_timer.sv | 44 ++++
 rtl/planes_cache_ctrl.sv | 158 +++++++++++++++
 tb/tb_planes_cache_ctrl.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/planes_cache_ctrl_pkg.sv
// Shared types and field helpers for the HUB75 scan sequencer.
// Address layout is {half, row, plane}, half bit in the MSB.
package planes_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ0,
        REQ1,
        SHIFT,
        LATCH,
        DISPLAY
    } state_t;

    function automatic int plane_lsb();
        return 0;
    endfunction

    function automatic int row_lsb(input int plane_bits);
        return plane_bits;
    endfunction

    function automatic int half_bit(input int row_bits, input int plane_bits);
        return row_bits + plane_bits;
    endfunction

    function automatic int addr_w(input int row_bits, input int plane_bits);
        return 1 + row_bits + plane_bits;
    endfunction

    // Down-counter width able to hold (BASE_TICKS<<(PLANES-1))-1.
    function automatic int disp_cnt_w(input int base_ticks, input int planes);
        int w;
        w = $clog2(base_ticks << (planes - 1));
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/planes_cache_ctrl_if.sv
// Frame-memory read channel: request/address out, ack back.
// Row-plane data travels straight to the planes cache.
interface planes_cache_ctrl_if #(
    parameter int ADDR_W = 9
);
    logic              out_MEM_REQ;
    logic [ADDR_W-1:0] out_MEM_ADDR;
    logic              in_MEM_ACK;

    modport master (
        output out_MEM_REQ,
        output out_MEM_ADDR,
        input  in_MEM_ACK
    );

    modport slave (
        input  out_MEM_REQ,
        input  out_MEM_ADDR,
        output in_MEM_ACK
    );
endinterface

// File: rtl/planes_cache_ctrl_bcm_plane_timer.sv
// Loadable down-counter timing one BCM display window.
// done_o is high in the last cycle of a BASE_TICKS<<plane window.
import planes_ctrl_pkg::*;

module bcm_plane_timer #(
    parameter int BASE_TICKS = 4,
    parameter int PLANES     = 8,
    parameter int PLANE_BITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [PLANE_BITS-1:0] plane_i,
    output logic                  done_o
);
    localparam int W = disp_cnt_w(BASE_TICKS, PLANES);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W:0]   len;

    // Load window length minus one on start, then count to zero.
    always_comb begin
        len   = (W+1)'(BASE_TICKS) << plane_i;
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = W'(len - (W+1)'(1));
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/planes_cache_ctrl.sv
// HUB75 scan sequencer: fetch row planes, shift, latch, BCM display.
// Rows advance outermost, bit-planes innermost.
import planes_ctrl_pkg::*;

module planes_cache_ctrl #(
    parameter int COLS       = 64,
    parameter int ROW_BITS   = 5,
    parameter int PLANES     = 8,
    parameter int BASE_TICKS = 4,
    parameter int PLANE_BITS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_EN,
    planes_cache_ctrl_if.master mem,
    output logic                out_LOAD0,
    output logic                out_LOAD1,
    output logic                out_SHIFT,
    output logic                out_PCLK,
    output logic                out_LAT,
    output logic                out_OE_N,
    output logic [ROW_BITS-1:0] out_ROW,
    output logic                out_FRAME_DONE
);
    localparam int PIX_W = (COLS > 1) ? $clog2(COLS) : 1;

    state_t                state_q;
    logic [ROW_BITS-1:0]   row_q;
    logic [PLANE_BITS-1:0] plane_q;
    logic [PIX_W-1:0]      pix_q;
    logic                  half_q;
    logic                  req_q;
    logic                  pclk_q;
    logic                  shift_q;
    logic                  lat_q;
    logic                  oe_n_q;
    logic [ROW_BITS-1:0]   row_out_q;
    logic                  done_q;
    logic                  disp_done;

    bcm_plane_timer #(
        .BASE_TICKS (BASE_TICKS),
        .PLANES     (PLANES),
        .PLANE_BITS (PLANE_BITS)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .start_i (state_q == LATCH),
        .plane_i (plane_q),
        .done_o  (disp_done)
    );

    // Scan FSM; every panel strobe is registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            row_q     <= '0;
            plane_q   <= '0;
            pix_q     <= '0;
            half_q    <= 1'b0;
            req_q     <= 1'b0;
            pclk_q    <= 1'b0;
            shift_q   <= 1'b0;
            lat_q     <= 1'b0;
            oe_n_q    <= 1'b1;
            row_out_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_EN) begin
                        state_q <= REQ0;
                        req_q   <= 1'b1;
                        half_q  <= 1'b0;
                    end
                end
                REQ0: begin
                    if (mem.in_MEM_ACK) begin
                        state_q <= REQ1;
                        half_q  <= 1'b1;
                    end
                end
                REQ1: begin
                    if (mem.in_MEM_ACK) begin
                        state_q <= SHIFT;
                        req_q   <= 1'b0;
                        half_q  <= 1'b0;
                        pix_q   <= '0;
                        pclk_q  <= 1'b0;
                        shift_q <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (!pclk_q) begin
                        pclk_q  <= 1'b1;
                        shift_q <= 1'b1;
                    end else begin
                        pclk_q  <= 1'b0;
                        shift_q <= 1'b0;
                        if (pix_q == PIX_W'(COLS - 1)) begin
                            state_q <= LATCH;
                            lat_q   <= 1'b1;
                        end else begin
                            pix_q <= pix_q + PIX_W'(1);
                        end
                    end
                end
                LATCH: begin
                    state_q   <= DISPLAY;
                    lat_q     <= 1'b0;
                    oe_n_q    <= 1'b0;
                    row_out_q <= row_q;
                end
                DISPLAY: begin
                    if (disp_done) begin
                        oe_n_q <= 1'b1;
                        if (plane_q != PLANE_BITS'(PLANES - 1)) begin
                            plane_q <= plane_q + PLANE_BITS'(1);
                            state_q <= REQ0;
                            req_q   <= 1'b1;
                        end else begin
                            plane_q <= '0;
                            row_q   <= row_q + ROW_BITS'(1);
                            if ((&row_q) && !in_EN) begin
                                state_q <= IDLE;
                            end else begin
                                state_q <= REQ0;
                                req_q   <= 1'b1;
                            end
                            if (&row_q) begin
                                done_q <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem.out_MEM_REQ  = req_q;
    assign mem.out_MEM_ADDR = {half_q, row_q, plane_q};

    // Loads follow the ack combinationally so the cache captures on that edge.
    assign out_LOAD0 = (state_q == REQ0) && mem.in_MEM_ACK;
    assign out_LOAD1 = (state_q == REQ1) && mem.in_MEM_ACK;

    assign out_SHIFT      = shift_q;
    assign out_PCLK       = pclk_q;
    assign out_LAT        = lat_q;
    assign out_OE_N       = oe_n_q;
    assign out_ROW        = row_out_q;
    assign out_FRAME_DONE = done_q;

endmodule

// File: tb/tb_planes_cache_ctrl.sv
// Self-checking bench for planes_cache_ctrl with random ack latency.
// Expected scan order is walked row by row, plane by plane.
module tb_planes_cache_ctrl;
    localparam int COLS       = 4;
    localparam int ROW_BITS   = 1;
    localparam int PLANES     = 2;
    localparam int BASE_TICKS = 2;
    localparam int PLANE_BITS = 1;
    localparam int ROWS       = 1 << ROW_BITS;
    localparam int AW         = 1 + ROW_BITS + PLANE_BITS;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                en  = 1'b1;
    logic                ack = 1'b0;
    logic                load0;
    logic                load1;
    logic                shift_o;
    logic                pclk;
    logic                lat_o;
    logic                oe_n;
    logic [ROW_BITS-1:0] row;
    logic                fdone;

    int n_cmp = 0;
    int n_err = 0;
    int row_disp = 0;

    planes_cache_ctrl_if #(.ADDR_W(AW)) mem ();
    assign mem.in_MEM_ACK = ack;

    planes_cache_ctrl #(
        .COLS       (COLS),
        .ROW_BITS   (ROW_BITS),
        .PLANES     (PLANES),
        .BASE_TICKS (BASE_TICKS),
        .PLANE_BITS (PLANE_BITS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_EN          (en),
        .mem            (mem),
        .out_LOAD0      (load0),
        .out_LOAD1      (load1),
        .out_SHIFT      (shift_o),
        .out_PCLK       (pclk),
        .out_LAT        (lat_o),
        .out_OE_N       (oe_n),
        .out_ROW        (row),
        .out_FRAME_DONE (fdone)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        ack = 1'b0;
    endtask

    function automatic int addr_of(input int half, input int r, input int p);
        return (half << (ROW_BITS + PLANE_BITS)) | (r << PLANE_BITS) | p;
    endfunction

    task automatic fetch(input int half, input int r, input int p, input int lat);
        for (int k = 0; k <= lat; k++) begin
            ack = (k == lat);
            #1;
            check("req", int'(mem.out_MEM_REQ), 1);
            check("addr", int'(mem.out_MEM_ADDR), addr_of(half, r, p));
            check("load0", int'(load0), (half == 0 && k == lat) ? 1 : 0);
            check("load1", int'(load1), (half == 1 && k == lat) ? 1 : 0);
            check("shift_f", int'(shift_o), 0);
            check("pclk_f", int'(pclk), 0);
            check("oe_n_f", int'(oe_n), 1);
            check("row_f", int'(row), row_disp);
            step();
        end
    endtask

    task automatic shift_px(input int npx);
        for (int px = 0; px < npx; px++) begin
            for (int ph = 0; ph < 2; ph++) begin
                ack = 1'($urandom_range(0, 1));
                #1;
                check("pclk", int'(pclk), ph);
                check("shift", int'(shift_o), ph);
                check("load0_s", int'(load0), 0);
                check("load1_s", int'(load1), 0);
                check("req_s", int'(mem.out_MEM_REQ), 0);
                check("lat_s", int'(lat_o), 0);
                check("oe_n_s", int'(oe_n), 1);
                step();
            end
        end
    endtask

    task automatic latch_disp(input int r, input int p, input int fin, input logic en_next);
        int n;
        int low;
        ack = 1'($urandom_range(0, 1));
        #1;
        check("lat", int'(lat_o), 1);
        check("oe_n_l", int'(oe_n), 1);
        check("pclk_l", int'(pclk), 0);
        check("row_l", int'(row), row_disp);
        check("load0_l", int'(load0), 0);
        step();
        row_disp = r;
        n = BASE_TICKS << p;
        low = 0;
        for (int i = 0; i < n; i++) begin
            ack = 1'($urandom_range(0, 1));
            if (fin == 0 && i == 0) en = 1'($urandom_range(0, 1));
            if (i == n - 1) en = (fin != 0) ? en_next : 1'($urandom_range(0, 1));
            #1;
            if (!oe_n) low++;
            check("row_d", int'(row), r);
            check("lat_d", int'(lat_o), 0);
            check("pclk_d", int'(pclk), 0);
            check("req_d", int'(mem.out_MEM_REQ), 0);
            check("load1_d", int'(load1), 0);
            check("fdone_d", int'(fdone), 0);
            step();
        end
        check("oe_low_cycles", low, n);
        #1;
        check("fdone", int'(fdone), fin);
        check("oe_n_post", int'(oe_n), 1);
    endtask

    initial begin
        int lat;
        int fin;
        logic en_next;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check("rst_oe_n", int'(oe_n), 1);
            check("rst_req", int'(mem.out_MEM_REQ), 0);
            check("rst_load0", int'(load0), 0);
            check("rst_shift", int'(shift_o), 0);
            check("rst_pclk", int'(pclk), 0);
            check("rst_lat", int'(lat_o), 0);
            check("rst_row", int'(row), 0);
            check("rst_fdone", int'(fdone), 0);
        end
        rst = 1'b0;
        #1;
        check("req_pre", int'(mem.out_MEM_REQ), 0);
        step();

        for (int f = 0; f < 3; f++) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int p = 0; p < PLANES; p++) begin
                    lat = (f == 0) ? 0 : (f == 1) ? 3 : int'($urandom_range(0, 3));
                    fetch(0, r, p, lat);
                    lat = (f == 0) ? 0 : (f == 1) ? 3 : int'($urandom_range(0, 3));
                    fetch(1, r, p, lat);
                    shift_px(COLS);
                    fin = (r == ROWS - 1 && p == PLANES - 1) ? 1 : 0;
                    en_next = (f == 0) ? 1'b0 : 1'b1;
                    latch_disp(r, p, fin, en_next);
                    if (fin != 0 && !en_next) begin
                        for (int c = 0; c < 3; c++) begin
                            check("idle_req", int'(mem.out_MEM_REQ), 0);
                            check("idle_oe_n", int'(oe_n), 1);
                            check("idle_fdone", int'(fdone), (c == 0) ? 1 : 0);
                            step();
                            #1;
                        end
                        en = 1'b1;
                        step();
                    end
                end
            end
        end

        fetch(0, 0, 0, 0);
        fetch(1, 0, 0, 1);
        shift_px(2);
        rst = 1'b1;
        step();
        check("mid_shift", int'(shift_o), 0);
        check("mid_pclk", int'(pclk), 0);
        check("mid_row", int'(row), 0);
        check("mid_oe_n", int'(oe_n), 1);
        check("mid_req", int'(mem.out_MEM_REQ), 0);
        check("mid_lat", int'(lat_o), 0);
        rst = 1'b0;
        en = 1'b1;
        row_disp = 0;
        step();
        fetch(0, 0, 0, 0);
        fetch(1, 0, 0, 2);
        shift_px(COLS);
        latch_disp(0, 0, 0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
